// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the W stage and a multi-cycle (mul/div) unit.
// A one-entry buffer absorbs port conflicts; a bounded wait forces a W-stage stall to drain it.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_we_W,
    input  logic [4:0]  rd_W,
    input  logic [31:0] final_result,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_result,
    output logic        md_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wd,
    output logic        stall_req,
    output logic        superseded
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  buf_rd_q, buf_rd_d;
    logic [31:0] buf_wd_q, buf_wd_d;
    logic        stall_req_q;
    logic        pw;
    logic        mw;
    logic        same_rd;

    assign pw        = reg_we_W && (rd_W != 5'd0);
    assign md_ready  = rst_n && (state_q == IDLE);
    assign mw        = md_valid && md_ready && (md_rd != 5'd0);
    assign same_rd   = (rd_W == buf_rd_q);
    assign stall_req = stall_req_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            buf_rd_q    <= 5'd0;
            buf_wd_q    <= 32'd0;
            stall_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_rd_q    <= buf_rd_d;
            buf_wd_q    <= buf_wd_d;
            stall_req_q <= (state_d == FORCE);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_rd_d = buf_rd_q;
        buf_wd_d = buf_wd_q;
        case (state_q)
            IDLE: begin
                if (pw && mw) begin
                    buf_rd_d = md_rd;
                    buf_wd_d = md_result;
                    cnt_d    = 4'd1;
                    state_d  = (LIMIT == 4'd1) ? FORCE : HELD;
                end
            end
            HELD: begin
                if (!pw || same_rd) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    // Each cycle the pipeline wins the port, the buffered result ages by one.
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == LIMIT) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rf_we      = 1'b0;
        rf_rd      = 5'd0;
        rf_wd      = 32'd0;
        superseded = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (pw) begin
                        rf_we = 1'b1;
                        rf_rd = rd_W;
                        rf_wd = final_result;
                    end else if (mw) begin
                        rf_we = 1'b1;
                        rf_rd = md_rd;
                        rf_wd = md_result;
                    end
                end
                HELD: begin
                    rf_we = 1'b1;
                    if (pw) begin
                        rf_rd      = rd_W;
                        rf_wd      = final_result;
                        superseded = same_rd;
                    end else begin
                        rf_rd = buf_rd_q;
                        rf_wd = buf_wd_q;
                    end
                end
                FORCE: begin
                    // W stage is being held; its write is replayed next cycle.
                    rf_we = 1'b1;
                    rf_rd = buf_rd_q;
                    rf_wd = buf_wd_q;
                end
                default: begin
                    rf_we = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios followed by random traffic,
// checked against an age-based model of the one-entry buffer.
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_we_W;
    logic [4:0]  rd_W;
    logic [31:0] final_result;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_result;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        stall_req;
    logic        superseded;

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_we_W(reg_we_W), .rd_W(rd_W), .final_result(final_result),
        .md_valid(md_valid), .md_rd(md_rd), .md_result(md_result),
        .md_ready(md_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
        .stall_req(stall_req), .superseded(superseded)
    );

    // Expected output bundle: {rf_we, rf_rd, rf_wd, md_ready, stall_req, superseded}
    logic [40:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Model: a buffered entry plus how many cycles it has waited so far.
    bit          m_has = 0;
    logic [4:0]  m_rd  = '0;
    logic [31:0] m_wd  = '0;
    int          m_age = 0;

    task automatic drive(input bit rst, input bit we, input logic [4:0] rd, input logic [31:0] d,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] mres);
        bit          e_we, e_rdy, e_stall, e_sup, pw, mw;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        @(posedge clk);
        #1;
        rst_n = rst; reg_we_W = we; rd_W = rd; final_result = d;
        md_valid = mv; md_rd = mrd; md_result = mres;

        e_we = 0; e_rd = '0; e_wd = '0; e_sup = 0;
        e_stall = m_has && (m_age == LIMIT);
        e_rdy   = rst && !m_has;
        pw = we && (rd != 0);
        mw = mv && e_rdy && (mrd != 0);
        if (!rst) begin
            m_has = 0;
        end else if (m_has && m_age == LIMIT) begin
            e_we = 1; e_rd = m_rd; e_wd = m_wd; m_has = 0;
        end else if (m_has) begin
            e_we = 1;
            if (!pw) begin
                e_rd = m_rd; e_wd = m_wd; m_has = 0;
            end else begin
                e_rd = rd; e_wd = d;
                if (rd == m_rd) begin
                    e_sup = 1; m_has = 0;
                end else begin
                    m_age++;
                end
            end
        end else if (pw) begin
            e_we = 1; e_rd = rd; e_wd = d;
            if (mw) begin
                m_has = 1; m_rd = mrd; m_wd = mres; m_age = 1;
            end
        end else if (mw) begin
            e_we = 1; e_rd = mrd; e_wd = mres;
        end
        exp_q.push_back({e_we, e_rd, e_wd, e_rdy, e_stall, e_sup});
    endtask

    task automatic idle_cycle();
        drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [40:0] e, a;
            e = exp_q.pop_front();
            a = {rf_we, rf_rd, rf_wd, md_ready, stall_req, superseded};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs @%0t: got we=%0b rd=%0d wd=%h rdy=%0b stall=%0b sup=%0b, want we=%0b rd=%0d wd=%h rdy=%0b stall=%0b sup=%0b",
                         $time, a[40], a[39:35], a[34:3], a[2], a[1], a[0],
                         e[40], e[39:35], e[34:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        rst_n = 0; reg_we_W = 0; rd_W = 0; final_result = 0;
        md_valid = 0; md_rd = 0; md_result = 0;
        repeat (2) @(posedge clk);

        drive(0, 1, 3, 32'h1, 1, 4, 32'h2);            // outputs gated during reset
        idle_cycle();
        drive(1, 0, 0, 0, 1, 5, 32'h1234);             // bypass
        drive(1, 1, 3, 32'hA, 1, 7, 32'hB);            // conflict: capture x7
        drive(1, 0, 0, 0, 1, 8, 32'hC);                // drain x7, md not ready
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 4, 32'h40, 1, 7, 32'h77);          // starvation: capture x7
        drive(1, 1, 1, 32'h11, 0, 0, 0);
        drive(1, 1, 2, 32'h22, 0, 0, 0);
        drive(1, 1, 3, 32'h33, 0, 0, 0);
        drive(1, 1, 3, 32'h33, 0, 0, 0);               // forced drain, pipeline ignored
        drive(1, 1, 3, 32'h33, 0, 0, 0);
        drive(1, 1, 2, 32'h20, 1, 9, 32'h55);          // supersede: capture x9
        drive(1, 1, 9, 32'h66, 0, 0, 0);
        idle_cycle();
        drive(1, 1, 0, 32'h5, 1, 0, 32'h9);            // zero register both sides
        idle_cycle();
        drive(1, 1, 6, 32'h60, 1, 10, 32'hAA);         // reset while held
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 11, 32'hBB);
        idle_cycle();

        for (int i = 0; i < 3000; i++) begin
            bit rst;
            rst = ($urandom_range(0, 63) != 0);
            drive(rst, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 5)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 5)), $urandom);
        end
        idle_cycle();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
